// File: rtl/arm_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and
// the fetch sequencer state encoding.
package arm_pkg;

    localparam int ARCH_DEFAULT = 32;
    localparam int AW_DEFAULT   = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {instruction, pc}, registered head,
// synchronous flush that takes priority over push and pop.
module fetch_fifo #(
    parameter int W     = 44,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/arm_fetch.sv
// Instruction fetch unit: single-outstanding memory sequencer feeding a prefetch FIFO.
// Define FETCH_PERF_EN to add the fetch_count / stall_count performance counters.
module arm_fetch
    import arm_pkg::*;
#(
    parameter int ARCH  = ARCH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [AW-1:0]   redirect_pc,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_ack,
    input  logic [ARCH-1:0] mem_rdata,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [ARCH-1:0] ins_data,
    output logic [AW-1:0]   ins_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [ARCH+AW-1:0] fifo_head;
    logic               in_flight;
    logic               slot_free;

    // A word still in flight has already claimed its slot.
    assign in_flight = (state_q == REQ);
    assign slot_free = (fifo_count + CW'(in_flight)) < CW'(DEPTH);

    assign fifo_push = (state_q == REQ) && mem_ack && !redirect && !fifo_full;
    assign fifo_pop  = ins_valid && ins_ready && !redirect;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (slot_free) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    state_d = IDLE;
                    if (fifo_push) begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // DRAIN keeps the request asserted so the abandoned transaction completes cleanly.
    assign mem_req  = (state_q != IDLE);
    assign mem_addr = addr_q;

    fetch_fifo #(
        .W     (ARCH + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ({mem_rdata, addr_q}),
        .pop_i       (fifo_pop),
        .flush_i     (redirect),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign ins_valid = !fifo_empty;
    assign ins_data  = fifo_head[ARCH+AW-1:AW];
    assign ins_pc    = fifo_head[AW-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (fifo_push) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (ins_ready && !ins_valid) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_arm_fetch.sv
// Self-checking bench for arm_fetch: a behavioural memory responder plus an
// in-order pc/data stream model (expected word at address a is a + 0xE2800000).
module tb_arm_fetch;

    localparam int ARCH  = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect;
    logic [AW-1:0]   redirect_pc;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack;
    logic [ARCH-1:0] mem_rdata;
    logic            ins_valid;
    logic            ins_ready;
    logic [ARCH-1:0] ins_data;
    logic [AW-1:0]   ins_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]     fetch_count;
    logic [31:0]     stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_fetch #(.ARCH(ARCH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    function automatic logic [ARCH-1:0] word_at(input logic [AW-1:0] a);
        return 32'hE280_0000 + ARCH'(a);
    endfunction

    // Memory responder: acks each request `lat` cycles after it first appears
    // (0 = same cycle), checks that the request stays stable until acked.
    int            lat = 0;
    bit            rand_lat = 1'b0;
    bit            pend = 1'b0;
    bit            stray = 1'b0;
    int            wait_n = 0;
    logic [AW-1:0] pend_addr = '0;
    int            ack_total = 0;
    logic [AW-1:0] ack_log[$];

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (pend && reset) stray = 1'b1;
        if (pend && !stray && !reset) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== pend_addr) begin
                errors++;
                $display("FAIL req_stable: mem_req=%0b mem_addr=%h, required 1 / %h", mem_req, mem_addr, pend_addr);
            end
        end
        if (!pend && mem_req === 1'b1 && !reset) begin
            pend      = 1'b1;
            stray     = 1'b0;
            pend_addr = mem_addr;
            wait_n    = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end else if (pend) begin
            wait_n--;
        end
        if (pend && wait_n <= 0) begin
            mem_ack   = 1'b1;
            mem_rdata = word_at(pend_addr);
            pend      = 1'b0;
            ack_total++;
            ack_log.push_back(pend_addr);
        end else begin
            mem_rdata = $urandom();
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
        redirect_pc = AW'($urandom());
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = AW'($urandom());
        ins_ready   = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_req, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mem: mem_req=%0b mem_addr=%h, required 0 / 000", mem_req, mem_addr);
        end
        checks++;
        if ({ins_valid, ins_data, ins_pc} !== '0) begin
            errors++;
            $display("FAIL reset_ins: valid=%0b data=%h pc=%h, required all zero", ins_valid, ins_data, ins_pc);
        end
        reset     = 1'b0;
        ins_ready = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL first_req: mem_req=%0b mem_addr=%h, required 1 / 000", mem_req, mem_addr);
        end
    endtask

    task automatic test_stream();
        logic [AW-1:0] exp_pc = '0;
        int n = 0;
        int c = 0;
        ins_ready = 1'b1;
        while (!mem_ack && c < 20) begin tick(); c++; end
        checks++;
        if (ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_on_ack: ins_valid=%0b, required 0", ins_valid);
        end
        tick();
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 12'h000) begin
            errors++;
            $display("FAIL valid_latency: ins_valid=%0b pc=%h, required 1 / 000", ins_valid, ins_pc);
        end
        for (int k = 0; k < 60 && n < 4; k++) begin
            if (ins_valid && ins_ready) begin
                checks++;
                if (ins_pc !== exp_pc || ins_data !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL stream: pc=%h data=%h, required %h / %h", ins_pc, ins_data, exp_pc, word_at(exp_pc));
                end
                exp_pc++;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words, required 4", n);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] exp_pc = 12'h040;
        int n = 0;
        int hits = 0;
        int req_high = 0;
        ins_ready = 1'b0;
        rand_lat  = 1'b1;
        ack_log.delete();
        do_redirect(12'h040);
        repeat (40) tick();
        for (int k = 0; k < 5; k++) begin
            if (mem_req) req_high++;
            tick();
        end
        foreach (ack_log[i]) if (ack_log[i] >= 12'h040 && ack_log[i] < 12'h050) hits++;
        checks++;
        if (hits != DEPTH) begin
            errors++;
            $display("FAIL bp_fill: %0d words fetched, required %0d", hits, DEPTH);
        end
        checks++;
        if (req_high != 0 || ins_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: mem_req high %0d cycles valid=%0b, required 0 / 1", req_high, ins_valid);
        end
        for (int k = 0; k < 200 && n < 8; k++) begin
            ins_ready = ($urandom_range(0, 99) < 50);
            if (ins_valid && ins_ready) begin
                checks++;
                if (ins_pc !== exp_pc || ins_data !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL bp_stream: pc=%h data=%h, required %h / %h", ins_pc, ins_data, exp_pc, word_at(exp_pc));
                end
                exp_pc++;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bp_timeout: got %0d words, required 8", n);
        end
    endtask

    task automatic test_redirect_inflight();
        int c = 0;
        bit seen_new = 1'b0;
        logic [AW-1:0] new_addr = '0;
        ins_ready = 1'b1;
        rand_lat  = 1'b0;
        lat       = 3;
        do_redirect(12'h005);
        while (!(mem_req && mem_addr == 12'h005) && c < 30) begin tick(); c++; end
        do_redirect(12'h100);
        lat = 1;
        c = 0;
        while (!ins_valid && c < 30) begin
            if (!seen_new && mem_req && mem_addr != 12'h005) begin
                seen_new = 1'b1;
                new_addr = mem_addr;
            end
            tick();
            c++;
        end
        checks++;
        if (!seen_new || new_addr !== 12'h100) begin
            errors++;
            $display("FAIL rd_next_addr: seen=%0b addr=%h, required 1 / 100", seen_new, new_addr);
        end
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 12'h100 || ins_data !== word_at(12'h100)) begin
            errors++;
            $display("FAIL rd_first_pc: valid=%0b pc=%h data=%h, required 1 / 100 / %h", ins_valid, ins_pc, ins_data, word_at(12'h100));
        end
    endtask

    task automatic test_redirect_coincident();
        int c = 0;
        logic prev = 1'b1;
        ins_ready = 1'b0;
        lat       = 2;
        do_redirect(12'h200);
        prev = mem_req;
        while (!(ins_valid && mem_req && !prev) && c < 40) begin
            prev = mem_req;
            tick();
            c++;
        end
        tick();
        tick();
        if (mem_ack !== 1'b1 || ins_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rc_setup: mem_ack=%0b valid=%0b, required 1 / 1", mem_ack, ins_valid);
        end
        redirect    = 1'b1;
        redirect_pc = 12'h300;
        ins_ready   = 1'b1;
        tick();
        redirect  = 1'b0;
        ins_ready = 1'b0;
        lat       = 0;
        checks++;
        if (ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL rc_empty: ins_valid=%0b, required 0", ins_valid);
        end
        c = 0;
        while (!ins_valid && c < 20) begin tick(); c++; end
        checks++;
        if (ins_pc !== 12'h300 || ins_data !== word_at(12'h300)) begin
            errors++;
            $display("FAIL rc_restart: pc=%h data=%h, required 300 / %h", ins_pc, ins_data, word_at(12'h300));
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_pc = 12'hFFE;
        int n = 0;
        ins_ready = 1'b1;
        rand_lat  = 1'b1;
        do_redirect(12'hFFE);
        for (int k = 0; k < 60 && n < 3; k++) begin
            if (ins_valid && ins_ready) begin
                checks++;
                if (ins_pc !== exp_pc || ins_data !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL wrap: pc=%h data=%h, required %h / %h", ins_pc, ins_data, exp_pc, word_at(exp_pc));
                end
                exp_pc++;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d words, required 3", n);
        end
    endtask

    task automatic test_reset_midreq();
        int c = 0;
        logic prev;
        logic [AW-1:0] exp_pc = '0;
        int n = 0;
        ins_ready = 1'b0;
        rand_lat  = 1'b0;
        lat       = 4;
        prev      = mem_req;
        while (!(mem_req && !prev) && c < 40) begin
            prev = mem_req;
            tick();
            c++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreq_abandon: mem_req=%0b valid=%0b, required 0 / 0", mem_req, ins_valid);
        end
        repeat (3) tick();
        if (mem_ack !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL midreq_setup: mem_ack=%0b, required 1", mem_ack);
        end
        reset = 1'b0;
        lat   = 0;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL midreq_restart: mem_req=%0b addr=%h, required 1 / 000", mem_req, mem_addr);
        end
        ins_ready = 1'b1;
        for (int k = 0; k < 40 && n < 2; k++) begin
            if (ins_valid && ins_ready) begin
                checks++;
                if (ins_pc !== exp_pc || ins_data !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL midreq_stream: pc=%h data=%h, required %h / %h", ins_pc, ins_data, exp_pc, word_at(exp_pc));
                end
                exp_pc++;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL midreq_timeout: got %0d words, required 2", n);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_pc = AW'($urandom());
        logic [AW-1:0] pc;
        int n = 0;
        rand_lat = 1'b1;
        do_redirect(exp_pc);
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 99) < 4) begin
                pc = AW'($urandom());
                do_redirect(pc);
                exp_pc = pc;
                checks++;
                if (ins_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_flush: ins_valid=%0b after redirect, required 0", ins_valid);
                end
            end
            ins_ready = ($urandom_range(0, 99) < 60);
            if (ins_valid && ins_ready) begin
                checks++;
                if (ins_pc !== exp_pc || ins_data !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_stream: pc=%h data=%h, required %h / %h", ins_pc, ins_data, exp_pc, word_at(exp_pc));
                end
                exp_pc++;
                n++;
            end
            tick();
        end
        checks++;
        if (n < 40) begin
            errors++;
            $display("FAIL rand_progress: %0d words delivered, required at least 40", n);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int c = 0;
        int stalls = 0;
        int base;
        while (pend && c < 20) begin tick(); c++; end
        rand_lat  = 1'b0;
        lat       = 0;
        ins_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        base  = ack_total;
        c     = 0;
        while (c < 200) begin
            ins_ready = (stalls < 3) ? 1'b1 : ins_valid;
            if (ins_ready && !ins_valid) stalls++;
            if (ack_total - base >= 10) break;
            tick();
            c++;
        end
        tick();
        ins_ready = 1'b0;
        checks++;
        if (fetch_count !== 32'd10) begin
            errors++;
            $display("FAIL perf_fetch: fetch_count=%0d, required 10", fetch_count);
        end
        checks++;
        if (stall_count !== 32'd3 || stalls != 3) begin
            errors++;
            $display("FAIL perf_stall: stall_count=%0d driven=%0d, required 3", stall_count, stalls);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        test_reset_midreq();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
